// File: rtl/rst_sequencer.sv
// Reset sequencer: after a hold period and clock lock, releases p_STAGES active-low
// resets in index order, waiting for each stage's ack (or a timeout) before the next.
module rst_sequencer #(
    parameter int p_STAGES  = 4,
    parameter int p_HOLD    = 16,
    parameter int p_GAP     = 4,
    parameter int p_ACK_TMO = 255,
    parameter int p_CNT_W   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_locked,
    input  logic                i_sw_rst,
    input  logic [p_STAGES-1:0] iv_ack,
    output logic [p_STAGES-1:0] ov_rst_n,
    output logic                o_ready,
    output logic                o_tmo,
    output logic [2:0]          ov_stage
);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_READY     = 3'd5;

    localparam logic [p_CNT_W-1:0] HOLD_LAST = p_CNT_W'(p_HOLD - 1);
    localparam logic [p_CNT_W-1:0] GAP_LAST  = p_CNT_W'(p_GAP - 1);
    localparam logic [p_CNT_W-1:0] TMO_LAST  = p_CNT_W'(p_ACK_TMO - 1);
    localparam logic [2:0]         LAST_STG  = 3'(p_STAGES - 1);

    logic [2:0]          state;
    logic [p_CNT_W-1:0]  cnt;
    logic [p_STAGES-1:0] stage_sel;
    logic                ack_cur;
    logic                is_last;
    logic                abort;

    // One-hot decode of the current stage; avoids indexing with a wider-than-needed index.
    always_comb begin
        stage_sel = '0;
        for (int k = 0; k < p_STAGES; k++)
            stage_sel[k] = (ov_stage == 3'(k));
    end

    assign ack_cur = |(iv_ack & stage_sel);
    assign is_last = (ov_stage == LAST_STG);

    // WAIT_LOCK is the state that waits out a missing lock, so only sw_rst aborts it.
    assign abort = (state != S_HOLD) &&
                   (i_sw_rst || (!i_locked && state != S_WAIT_LOCK));

    // NOTE: every register here is updated with <= so all reads see the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_HOLD;
            cnt      <= '0;
            ov_rst_n <= '0;
            o_ready  <= 1'b0;
            o_tmo    <= 1'b0;
            ov_stage <= '0;
        end else if (abort) begin
            state    <= S_HOLD;
            cnt      <= '0;
            ov_rst_n <= '0;
            o_ready  <= 1'b0;
            ov_stage <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (i_sw_rst) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (i_locked) begin
                        ov_stage <= '0;
                        state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    ov_rst_n <= ov_rst_n | stage_sel;
                    cnt      <= '0;
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_cur || cnt == TMO_LAST) begin
                        // A timed-out stage stays released; ack wins a tie with the timeout.
                        if (!ack_cur)
                            o_tmo <= 1'b1;
                        if (is_last) begin
                            o_ready <= 1'b1;
                            state   <= S_READY;
                        end else begin
                            cnt   <= '0;
                            state <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        ov_stage <= ov_stage + 3'd1;
                        state    <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_READY: begin
                    o_ready  <= 1'b1;
                    ov_rst_n <= '1;
                end
                default: begin
                    state    <= S_HOLD;
                    cnt      <= '0;
                    ov_rst_n <= '0;
                    o_ready  <= 1'b0;
                    ov_stage <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed timing scenarios plus randomized
// traffic compared each cycle against a countdown-based reference model.
module tb_rst_sequencer;

    localparam int S    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int TMO  = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         locked;
    logic         sw_rst;
    logic [S-1:0] ack;
    logic [S-1:0] rst_o;
    logic         ready;
    logic         tmo;
    logic [2:0]   stage;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Stimulus controls: per-stage ack latency after release, plus random noise on ack.
    int           dly [S];
    logic [S-1:0] noise_mask;

    // Reference model state.
    logic [S-1:0] m_rst;
    logic         m_ready;
    logic         m_tmo;
    int           m_stage;
    int           m_hold_left;
    int           m_release_in;
    int           m_target;
    bit           m_awaiting;
    int           m_wait_n;
    int           m_age [S];

    rst_sequencer #(
        .p_STAGES (S),
        .p_HOLD   (HOLD),
        .p_GAP    (GAP),
        .p_ACK_TMO(TMO),
        .p_CNT_W  (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_locked(locked),
        .i_sw_rst(sw_rst),
        .iv_ack  (ack),
        .ov_rst_n(rst_o),
        .o_ready (ready),
        .o_tmo   (tmo),
        .ov_stage(stage)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_rst        = '0;
        m_ready      = 1'b0;
        m_stage      = 0;
        m_hold_left  = HOLD;
        m_release_in = 0;
        m_target     = 0;
        m_awaiting   = 1'b0;
        m_wait_n     = 0;
        for (int k = 0; k < S; k++) m_age[k] = 0;
    endtask

    // One clock edge of the reference, using the inputs sampled at that edge.
    task automatic model_step();
        bit in_hold, wait_lock, done;
        if (!rst_n) begin
            model_clear();
            m_tmo = 1'b0;
            return;
        end
        in_hold   = (m_hold_left > 0);
        wait_lock = !in_hold && m_release_in == 0 && !m_awaiting && !m_ready;
        if (!in_hold && (sw_rst || (!locked && !wait_lock))) begin
            model_clear();
            return;
        end
        for (int k = 0; k < S; k++) if (m_rst[k]) m_age[k]++;
        if (in_hold) begin
            if (sw_rst) m_hold_left = HOLD;
            else        m_hold_left--;
        end else if (wait_lock) begin
            if (locked) begin
                m_release_in = 1;
                m_target     = 0;
                m_stage      = 0;
            end
        end else if (m_release_in > 0) begin
            m_release_in--;
            if (m_release_in <= 1) m_stage = m_target;
            if (m_release_in == 0) begin
                m_rst[m_target] = 1'b1;
                m_age[m_target] = 0;
                m_awaiting      = 1'b1;
                m_wait_n        = 0;
            end
        end else if (m_awaiting) begin
            m_wait_n++;
            done = 1'b0;
            if (ack[m_stage]) begin
                done = 1'b1;
            end else if (m_wait_n == TMO) begin
                m_tmo = 1'b1;
                done  = 1'b1;
            end
            if (done) begin
                m_awaiting = 1'b0;
                if (m_stage == S - 1) begin
                    m_ready = 1'b1;
                end else begin
                    m_target     = m_stage + 1;
                    m_release_in = GAP + 1;
                end
            end
        end
    endtask

    task automatic tick();
        logic [S-1:0] a;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        for (int k = 0; k < S; k++) a[k] = m_rst[k] && (m_age[k] >= dly[k]);
        ack = a | (S'($urandom) & noise_mask);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_rise(input int k, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rst_o[k] === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ready === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sw_rst = 1'($urandom);
        locked = 1'($urandom);
        rst_n  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (rst_o !== '0) begin n_fail++; $display("FAIL reset_rst_n: got %b expected 0000", rst_o); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b expected 0", tmo); end
        n_checks++;
        if (stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage: got %0d expected 0", stage); end
        sw_rst = 1'b0;
        locked = 1'b1;
    endtask

    task automatic test_nominal();
        int t0, tr;
        int rise [S];
        locked = 1'b1;
        sw_rst = 1'b0;
        for (int k = 0; k < S; k++) dly[k] = 0;
        do_reset();
        t0 = cyc;
        for (int k = 0; k < S; k++) begin
            wait_rise(k, 100, rise[k]);
            n_checks++;
            if (rise[k] !== t0 + HOLD + 2 + k * (GAP + 2)) begin
                n_fail++;
                $display("FAIL nominal_rise%0d: got edge %0d expected %0d", k, rise[k] - t0,
                         HOLD + 2 + k * (GAP + 2));
            end
        end
        wait_ready(20, tr);
        n_checks++;
        if (tr !== rise[S-1] + 1) begin
            n_fail++; $display("FAIL nominal_ready: got edge %0d expected %0d", tr, rise[S-1] + 1);
        end
        n_checks++;
        if (tmo !== 1'b0 || rst_o !== '1) begin
            n_fail++; $display("FAIL nominal_final: got tmo=%b rst_n=%b expected tmo=0 rst_n=1111", tmo, rst_o);
        end
    endtask

    task automatic test_lock_gating();
        int bad, tl, t;
        locked = 1'b0;
        do_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rst_o !== '0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL lock_hold: got %0d released cycles expected 0", bad); end
        locked = 1'b1;
        tl = cyc;
        wait_rise(0, 20, t);
        n_checks++;
        if (t !== tl + 2) begin n_fail++; $display("FAIL lock_release: got %0d edges expected 2", t - tl); end
        wait_ready(100, t);
    endtask

    task automatic test_timeout();
        int r1, tt, r2, r3, t;
        dly[1] = 100000;
        do_reset();
        wait_rise(1, 100, r1);
        tt = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tmo === 1'b1) begin tt = cyc; break; end
        end
        n_checks++;
        if (tt !== r1 + TMO) begin n_fail++; $display("FAIL tmo_edge: got %0d edges expected %0d", tt - r1, TMO); end
        wait_rise(2, 50, r2);
        n_checks++;
        if (r2 !== tt + GAP + 1) begin n_fail++; $display("FAIL tmo_stage2: got %0d expected %0d", r2, tt + GAP + 1); end
        wait_rise(3, 50, r3);
        n_checks++;
        if (r3 !== r2 + GAP + 2) begin n_fail++; $display("FAIL tmo_stage3: got %0d expected %0d", r3, r2 + GAP + 2); end
        wait_ready(20, t);
        n_checks++;
        if (ready !== 1'b1 || rst_o !== '1) begin
            n_fail++; $display("FAIL tmo_ready: got ready=%b rst_n=%b expected 1/1111", ready, rst_o);
        end
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        n_checks++;
        if (tmo !== 1'b1 || rst_o !== '0) begin
            n_fail++; $display("FAIL tmo_sticky_sw: got tmo=%b rst_n=%b expected 1/0000", tmo, rst_o);
        end
        dly[1] = 0;
        wait_ready(100, t);
        n_checks++;
        if (tmo !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL tmo_sticky_rerun: got tmo=%b ready=%b expected 1/1", tmo, ready);
        end
    endtask

    task automatic test_reset_clears_tmo();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", tmo); end
    endtask

    task automatic test_abort_mid();
        int t2, tp, t0, extra;
        dly[2] = 20;
        do_reset();
        wait_rise(2, 100, t2);
        extra = $urandom_range(0, 10);
        repeat (extra) tick();
        n_checks++;
        if (stage !== 3'd2) begin n_fail++; $display("FAIL abort_pre_stage: got %0d expected 2", stage); end
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        tp = cyc;
        n_checks++;
        if (rst_o !== '0 || stage !== 3'd0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear: got rst_n=%b stage=%0d ready=%b expected 0000/0/0", rst_o, stage, ready);
        end
        wait_rise(0, 40, t0);
        n_checks++;
        if (t0 !== tp + HOLD + 2) begin n_fail++; $display("FAIL abort_restart: got %0d edges expected %0d", t0 - tp, HOLD + 2); end
        dly[2] = 0;
        wait_ready(100, t0);
    endtask

    task automatic test_lock_loss_ready();
        int tl, t;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL lockloss_pre: got ready=%b expected 1", ready); end
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tl = cyc;
        n_checks++;
        if (rst_o !== '0 || ready !== 1'b0 || stage !== 3'd0) begin
            n_fail++; $display("FAIL lockloss_clear: got rst_n=%b ready=%b stage=%0d expected 0000/0/0", rst_o, ready, stage);
        end
        wait_rise(0, 40, t);
        n_checks++;
        if (t !== tl + HOLD + 2) begin n_fail++; $display("FAIL lockloss_restart: got %0d edges expected %0d", t - tl, HOLD + 2); end
        wait_ready(100, t);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL lockloss_ready: got %b expected 1", ready); end
    endtask

    task automatic test_held_sw();
        int bad, tf, t;
        sw_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rst_o !== '0) bad++;
        end
        sw_rst = 1'b0;
        tf = cyc;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL heldsw_hold: got %0d released cycles expected 0", bad); end
        wait_rise(0, 40, t);
        n_checks++;
        if (t !== tf + HOLD + 2) begin n_fail++; $display("FAIL heldsw_release: got %0d edges expected %0d", t - tf, HOLD + 2); end
        wait_ready(100, t);
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 40; ep++) begin
            for (int k = 0; k < S; k++)
                dly[k] = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 6));
            noise_mask = S'($urandom);
            locked = 1'b1;
            sw_rst = 1'b0;
            if ($urandom_range(0, 1) == 0) do_reset();
            for (int i = 0; i < 400; i++) begin
                tick();
                n_checks++;
                if (rst_o !== m_rst) begin n_fail++; $display("FAIL rand_rst_n cyc=%0d: got %b expected %b", cyc, rst_o, m_rst); end
                n_checks++;
                if (ready !== m_ready) begin n_fail++; $display("FAIL rand_ready cyc=%0d: got %b expected %b", cyc, ready, m_ready); end
                n_checks++;
                if (tmo !== m_tmo) begin n_fail++; $display("FAIL rand_tmo cyc=%0d: got %b expected %b", cyc, tmo, m_tmo); end
                n_checks++;
                if (stage !== 3'(m_stage)) begin n_fail++; $display("FAIL rand_stage cyc=%0d: got %0d expected %0d", cyc, stage, m_stage); end
                sw_rst = ($urandom_range(0, 199) == 0);
                locked = ($urandom_range(0, 149) != 0);
            end
        end
        noise_mask = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        locked     = 1'b0;
        sw_rst     = 1'b0;
        ack        = '0;
        noise_mask = '0;
        for (int k = 0; k < S; k++) dly[k] = 0;
        model_clear();
        m_tmo = 1'b0;

        test_reset();
        test_nominal();
        test_lock_gating();
        test_timeout();
        test_reset_clears_tmo();
        test_abort_mid();
        test_lock_loss_ready();
        test_held_sw();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumer side of the power-on reset output.
- Takes a single raw reset (the inverted power-on-reset pulse, or a board reset) plus a clock-locked indication and a software reset request.
- Releases p_STAGES downstream active-low resets one at a time, in order. Each stage must acknowledge readiness before the next is released.
- Sits at the top level between the power-on-reset generator and the subsystem resets (PHY, MAC, DMA, CPU).

Parameters:
- p_STAGES, 4, number of sequenced reset outputs (1..8).
- p_HOLD, 16, minimum cycles all outputs stay asserted after any reset cause (>=2).
- p_GAP, 4, idle cycles between a stage's ack and the next stage's release (>=1).
- p_ACK_TMO, 255, cycles to wait for a stage ack before forcing progress (>=1).
- p_CNT_W, 8, internal counter width; must hold max(p_HOLD, p_GAP, p_ACK_TMO).

Ports:
- i_clk, in, 1: system clock.
- i_rst_n, in, 1: synchronous, active-low reset.
- i_locked, in, 1: clock source stable; 0 forces re-sequencing.
- i_sw_rst, in, 1: software reset request, level-sensitive.
- iv_ack, in, p_STAGES: per-stage ready acknowledge, level.
- ov_rst_n, out, p_STAGES: sequenced stage resets, active-low, registered.
- o_ready, out, 1: all stages released and acknowledged.
- o_tmo, out, 1: sticky flag, some stage ack timed out.
- ov_stage, out, 3: index of the stage currently being released or awaited.

Behaviour:
- Reset (i_rst_n=0, sampled on the i_clk edge): ov_rst_n=all 0, o_ready=0, o_tmo=0, ov_stage=0, counter=0, state=HOLD.
- All outputs are registered; no combinational paths from inputs to outputs.
- HOLD:
  - Counter increments each cycle.
  - When counter==p_HOLD-1: clear counter, go to WAIT_LOCK.
  - If i_sw_rst=1: counter is cleared instead, so the hold extends while the request is held.
- WAIT_LOCK: stay until i_locked=1, then go to RELEASE with ov_stage=0.
- RELEASE: on the next edge, set ov_rst_n[ov_stage]=1, clear counter, go to WAIT_ACK.
- WAIT_ACK:
  - Counter increments each cycle.
  - If iv_ack[ov_stage]=1: proceed.
  - Else if counter==p_ACK_TMO-1: set o_tmo=1 and proceed. The stage stays released.
  - Proceed means: go to READY if ov_stage==p_STAGES-1, otherwise clear counter and go to GAP.
  - If ack and timeout occur in the same cycle, ack wins and o_tmo is unchanged.
- GAP: after p_GAP cycles (counter==p_GAP-1), increment ov_stage and go to RELEASE.
- READY: o_ready=1, all ov_rst_n=1.
- Abort: in any state other than HOLD, i_sw_rst=1 or i_locked=0 causes, on the next edge:
  - ov_rst_n=all 0, o_ready=0, ov_stage=0, counter=0, state=HOLD.
  - This applies mid-sequence as well as from READY.
- Stage order: stage k is never released before stage k-1; releases are monotonic in index.
- Stage acks: iv_ack bits for stages not being awaited are ignored. An ack already high when WAIT_ACK is entered counts on the first WAIT_ACK cycle.
- o_tmo is cleared only by i_rst_n, never by abort or i_sw_rst.
- Release timing: with i_locked=1 throughout, ov_rst_n[0] rises exactly p_HOLD+2 edges after the first edge sampling i_rst_n=1.
- Inter-stage timing: with ack returned in the first WAIT_ACK cycle, stage k+1 rises p_GAP+2 edges after stage k.

Test Plan:
1. Nominal sequence. Defaults, i_locked=1, iv_ack tied to ov_rst_n.
   - Required: ov_rst_n[0] rises at edge 18 after reset release; stages 1, 2, 3 follow at 6-edge spacing.
   - Required: o_ready=1 one edge after stage 3's ack; o_tmo=0.
2. Lock gating. i_locked=0 for 100 cycles after reset, then 1.
   - Required: ov_rst_n stays 0000 until 2 edges after i_locked rises, then stage 0 releases.
3. Timeout. iv_ack[1] held 0.
   - Required: o_tmo goes 1 after 255 WAIT_ACK cycles; stages 2 and 3 still release; o_ready=1.
   - Required: o_tmo stays 1 through a later i_sw_rst pulse.
4. Mid-sequence abort. Pulse i_sw_rst for 1 cycle while stage 2 is awaited.
   - Required: next edge gives ov_rst_n=0000, ov_stage=0, o_ready=0.
   - Required: full sequence repeats, with stage 0 released 18 edges after the pulse.
5. Lock loss in READY. Drop i_locked for 1 cycle.
   - Required: all resets assert next edge; sequence restarts once i_locked=1.
6. Held software reset. i_sw_rst high for 50 cycles from READY.
   - Required: ov_rst_n=0000 throughout; stage 0 released exactly p_HOLD+2 edges after i_sw_rst falls.
